// File: rtl/pe_driver_pkg.sv
// Shared encodings for the PE command front-end: op codes, FSM states, PE control words
// and d0 header patterns.
package pe_driver_pkg;

   typedef enum logic [1:0] {
      OP_MULT = 2'd0,
      OP_CUBE = 2'd1,
      OP_ADD  = 2'd2,
      OP_SUB  = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StLoad,
      StRun,
      StDrain,
      StHold
   } state_e;

   localparam logic [10:0] CTRL_LOAD   = 11'b11111_000000;
   localparam logic [10:0] CTRL_MULT   = 11'b00000_111111;
   localparam logic [10:0] CTRL_CUBE   = 11'b00000_000001;
   localparam logic [10:0] CTRL_ADDSUB = 11'b00000_010001;

   localparam logic [5:0] HDR_CUBE = 6'b010101;
   localparam logic [5:0] HDR_ADD  = 6'b000101;
   localparam logic [5:0] HDR_SUB  = 6'b001001;

endpackage

// File: rtl/pe_driver_op_decode.sv
// Combinational op decoder: maps a field operation and its operands onto the PE
// RUN-phase control word and the d0/d1/d2 operand buses.
module pe_op_decode
   import pe_driver_pkg::*;
#(
   parameter int unsigned W   = 194,
   parameter int unsigned D0W = 198
) (
   input  op_e            i_op,
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic [10:0]    o_run_ctrl,
   output logic [D0W-1:0] o_d0,
   output logic [W-1:0]   o_d1,
   output logic [W-1:0]   o_d2
);

   always_comb begin
      o_run_ctrl = CTRL_MULT;
      o_d0       = {{(D0W - W){1'b0}}, i_a};
      o_d1       = i_b;
      o_d2       = i_b;
      unique case (i_op)
         OP_MULT: begin
            o_run_ctrl = CTRL_MULT;
            o_d0       = {{(D0W - W){1'b0}}, i_a};
            o_d1       = i_b;
            o_d2       = i_b;
         end
         OP_CUBE: begin
            o_run_ctrl = CTRL_CUBE;
            o_d0       = {HDR_CUBE, {(D0W - 6){1'b0}}};
            o_d1       = i_a;
            o_d2       = i_a;
         end
         OP_ADD: begin
            o_run_ctrl = CTRL_ADDSUB;
            o_d0       = {HDR_ADD, {(D0W - 6){1'b0}}};
            o_d1       = i_a;
            o_d2       = i_b;
         end
         OP_SUB: begin
            o_run_ctrl = CTRL_ADDSUB;
            o_d0       = {HDR_SUB, {(D0W - 6){1'b0}}};
            o_d1       = i_a;
            o_d2       = i_b;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/pe_driver.sv
// Command front-end for the GF(3^97) PE: sequences CLR/LOAD/RUN/DRAIN and returns the result.
// Optional PE_DRIVER_PERF_EN adds o_perf_ops / o_perf_busy counters.
module pe_driver
   import pe_driver_pkg::*;
#(
   parameter int unsigned W    = 194,
   parameter int unsigned D0W  = 198,
   parameter int unsigned ITER = 33
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_cmd_valid,
   output logic           o_cmd_ready,
   input  logic [1:0]     i_cmd_op,
   input  logic [W-1:0]   i_cmd_a,
   input  logic [W-1:0]   i_cmd_b,
   output logic           o_pe_reset,
   output logic [10:0]    o_pe_ctrl,
   output logic [D0W-1:0] o_pe_d0,
   output logic [W-1:0]   o_pe_d1,
   output logic [W-1:0]   o_pe_d2,
   input  logic [W-1:0]   i_pe_out,
   output logic           o_res_valid,
   input  logic           i_res_ready,
   output logic [W-1:0]   o_res_data
`ifdef PE_DRIVER_PERF_EN
   ,
   output logic [15:0]    o_perf_ops,
   output logic [31:0]    o_perf_busy
`endif
);

   localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

   state_e          r_state;
   state_e          w_state_next;
   op_e             r_op;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_res_data;
   logic            r_res_valid;
   logic [CntW-1:0] r_cnt;
   logic            w_accept;
   logic            w_run_done;
   logic [10:0]     w_run_ctrl;

   assign w_accept   = i_reset && (r_state == StIdle) && i_cmd_valid;
   assign w_run_done = (r_cnt == CntW'(ITER - 1));

   // Operands come from registers so d0/d1/d2 stay frozen from CLR through DRAIN.
   pe_op_decode #(
      .W   (W),
      .D0W (D0W)
   ) u_decode (
      .i_op       (r_op),
      .i_a        (r_a),
      .i_b        (r_b),
      .o_run_ctrl (w_run_ctrl),
      .o_d0       (o_pe_d0),
      .o_d1       (o_pe_d1),
      .o_d2       (o_pe_d2)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= StIdle;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_cmd_valid) w_state_next = StClr;
         StClr:   w_state_next = StLoad;
         StLoad:  w_state_next = StRun;
         StRun:   if (w_run_done) w_state_next = StDrain;
         StDrain: w_state_next = StHold;
         StHold:  if (i_res_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_cmd_ready = 1'b0;
      o_pe_reset  = !i_reset;
      o_pe_ctrl   = '0;
      if (i_reset) begin
         unique case (r_state)
            StIdle:  o_cmd_ready = 1'b1;
            StClr:   o_pe_reset  = 1'b1;
            StLoad:  o_pe_ctrl   = CTRL_LOAD;
            StRun:   o_pe_ctrl   = w_run_ctrl;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_op        <= OP_MULT;
         r_a         <= '0;
         r_b         <= '0;
         r_cnt       <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
      end else begin
         if (w_accept) begin
            r_op <= op_e'(i_cmd_op);
            r_a  <= i_cmd_a;
            r_b  <= i_cmd_b;
         end
         r_cnt <= (r_state == StRun) ? r_cnt + 1'b1 : '0;
         if (r_state == StDrain) begin
            r_res_valid <= 1'b1;
            r_res_data  <= i_pe_out;
         end else if (r_state == StHold && i_res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   // A result still held when reset arrives is withdrawn in that same cycle.
   assign o_res_valid = r_res_valid && i_reset;
   assign o_res_data  = r_res_data;

`ifdef PE_DRIVER_PERF_EN
   logic [15:0] r_perf_ops;
   logic [31:0] r_perf_busy;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_perf_ops  <= '0;
         r_perf_busy <= '0;
      end else begin
         if (r_state == StHold && i_res_ready && r_perf_ops != 16'hFFFF) begin
            r_perf_ops <= r_perf_ops + 16'd1;
         end
         if (r_state != StIdle) r_perf_busy <= r_perf_busy + 32'd1;
      end
   end

   assign o_perf_ops  = r_perf_ops;
   assign o_perf_busy = r_perf_busy;
`endif

endmodule

// File: tb/tb_pe_driver.sv
// Self-checking bench for pe_driver with a behavioural PE stand-in that only yields its
// result after exactly ITER RUN cycles following LOAD.
module tb_pe_driver;

   localparam int W    = 194;
   localparam int D0W  = 198;
   localparam int ITER = 33;

   localparam logic [10:0] C_LOAD   = 11'b11111_000000;
   localparam logic [10:0] C_MULT   = 11'b00000_111111;
   localparam logic [10:0] C_CUBE   = 11'b00000_000001;
   localparam logic [10:0] C_ADDSUB = 11'b00000_010001;

   localparam logic [W-1:0] MA   = 194'h15a25886512165251569195908560596a6695612620504191;
   localparam logic [W-1:0] MB   = 194'h159546442405a181195655549614540592955a15a26984015;
   localparam logic [W-1:0] MR   = 194'h21019120440545215a1462a194a24a6019441081402410969;
   localparam logic [W-1:0] CA   = 194'h0894286a45940549565566512aa04a15558406850485454a4;
   localparam logic [W-1:0] CR   = 194'h1049480a48a0855a494855810160a90956659914560616652;
   localparam logic [W-1:0] SA   = 194'h0994544a41588446516618a14691a545542521a4158868428;
   localparam logic [W-1:0] SB   = 194'h1901269451681914415481656104980811a5a555155546949;
   localparam logic [W-1:0] SADD = 194'h16954a129284915a928a9916a4954141659a96092a11a2165;
   localparam logic [W-1:0] SSUB = 194'h209661a62020aa6210125a481599194946404852006625aa2;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           cmd_valid = 1'b0;
   logic           res_ready = 1'b0;
   logic [1:0]     cmd_op = 2'd0;
   logic [W-1:0]   cmd_a = '0;
   logic [W-1:0]   cmd_b = '0;
   logic [W-1:0]   pe_out = '0;
   logic           cmd_ready;
   logic           pe_reset;
   logic [10:0]    pe_ctrl;
   logic [D0W-1:0] pe_d0;
   logic [W-1:0]   pe_d1;
   logic [W-1:0]   pe_d2;
   logic           res_valid;
   logic [W-1:0]   res_data;
`ifdef PE_DRIVER_PERF_EN
   logic [15:0]    perf_ops;
   logic [31:0]    perf_busy;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int exp_ops  = 0;
   int exp_busy = 0;

   pe_driver dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_op    (cmd_op),
      .i_cmd_a     (cmd_a),
      .i_cmd_b     (cmd_b),
      .o_pe_reset  (pe_reset),
      .o_pe_ctrl   (pe_ctrl),
      .o_pe_d0     (pe_d0),
      .o_pe_d1     (pe_d1),
      .o_pe_d2     (pe_d2),
      .i_pe_out    (pe_out),
      .o_res_valid (res_valid),
      .i_res_ready (res_ready),
      .o_res_data  (res_data)
`ifdef PE_DRIVER_PERF_EN
      ,
      .o_perf_ops  (perf_ops),
      .o_perf_busy (perf_busy)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] rnd_vec();
      logic [223:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd_trits();
      logic [W-1:0] v;
      for (int i = 0; i < W / 2; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
      return v;
   endfunction

   // Digit-wise GF(3) add/sub of 97 packed trits.
   function automatic logic [W-1:0] trit_addsub(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input bit sub);
      logic [W-1:0] r;
      int s;
      r = '0;
      for (int i = 0; i < W / 2; i++) begin
         s = int'(x[2*i +: 2]) + (sub ? 3 - int'(y[2*i +: 2]) : int'(y[2*i +: 2]));
         r[2*i +: 2] = 2'(s % 3);
      end
      return r;
   endfunction

   // Stand-in for the field multiply/cube: reference vectors map to their known results.
   function automatic logic [W-1:0] mix(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W-1:0] z);
      return x ^ {y[0], y[W-1:1]} ^ {z[W-2:0], z[W-1]};
   endfunction

   function automatic logic [W-1:0] pe_mult(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] z);
      return (x == MA && y == MB && z == MB) ? MR : mix(x, y, z);
   endfunction

   function automatic logic [W-1:0] pe_cube(input logic [W-1:0] y, input logic [W-1:0] z);
      return (y == CA && z == CA) ? CR : mix(y, z, ~y);
   endfunction

   function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      case (op)
         2'd0:    return pe_mult(a, b, b);
         2'd1:    return pe_cube(a, a);
         2'd2:    return trit_addsub(a, b, 1'b0);
         default: return trit_addsub(a, b, 1'b1);
      endcase
   endfunction

   function automatic logic [D0W-1:0] hdr(input logic [5:0] h);
      return {h, {(D0W - 6){1'b0}}};
   endfunction

   function automatic logic [W-1:0] pe_eval(input logic [5:0] word, input logic [D0W-1:0] d0,
                                            input logic [W-1:0] d1, input logic [W-1:0] d2);
      if (word == 6'b111111 && d0[D0W-1:W] == '0) return pe_mult(d0[W-1:0], d1, d2);
      if (word == 6'b000001 && d0 == hdr(6'b010101)) return pe_cube(d1, d2);
      if (word == 6'b010001 && d0 == hdr(6'b000101)) return trit_addsub(d1, d2, 1'b0);
      if (word == 6'b010001 && d0 == hdr(6'b001001)) return trit_addsub(d1, d2, 1'b1);
      return rnd_vec();
   endfunction

   // PE model: garbage on pe_out except after exactly ITER run cycles since LOAD.
   int          m_cnt = 0;
   bit          m_loaded = 1'b0;
   logic [5:0]  m_word = '0;
   always @(negedge clk) begin
      if (pe_reset === 1'b1) begin
         m_cnt = 0;
         m_loaded = 1'b0;
      end else if (pe_ctrl === C_LOAD) begin
         m_cnt = 0;
         m_loaded = 1'b1;
      end else if (pe_ctrl !== 11'd0) begin
         m_cnt++;
         m_word = pe_ctrl[5:0];
      end
      if (m_loaded && m_cnt == ITER && pe_ctrl === 11'd0) pe_out = pe_eval(m_word, pe_d0, pe_d1, pe_d2);
      else pe_out = rnd_vec();
   end

   function automatic logic [10:0] exp_ctrl(input logic [1:0] op, input int k);
      if (k == 2) return C_LOAD;
      if (k >= 3 && k <= ITER + 2) return (op == 2'd0) ? C_MULT : (op == 2'd1) ? C_CUBE : C_ADDSUB;
      return 11'd0;
   endfunction

   function automatic logic [D0W-1:0] exp_d0(input logic [1:0] op, input logic [W-1:0] a);
      case (op)
         2'd0:    return {4'b0, a};
         2'd1:    return hdr(6'b010101);
         2'd2:    return hdr(6'b000101);
         default: return hdr(6'b001001);
      endcase
   endfunction

   // Issues one command and observes it to completion; k counts negedges after the accept.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, output int lat, output logic [W-1:0] data,
                         output bit seq_ok, output bit stall_ok, output bit idle_ok,
                         output int acc_cyc);
      int t;
      int k;
      logic [W-1:0] e1;
      logic [W-1:0] e2;
      seq_ok = 1'b1; stall_ok = 1'b1; idle_ok = 1'b0; lat = -1; data = '0;
      e1 = (op == 2'd0) ? b : a;
      e2 = (op == 2'd1) ? a : b;
      res_ready = (hold == 0);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      acc_cyc = cyc;
      if (cmd_ready !== 1'b1) begin
         cmd_valid = 1'b0;
         seq_ok = 1'b0;
         return;
      end
      k = 0;
      while (lat < 0 && k < ITER + 10) begin
         @(negedge clk);
         k++;
         cmd_valid = 1'b0;
         if (res_valid === 1'b1) begin
            lat = k;
            data = res_data;
         end else if (k <= ITER + 3) begin
            if (cmd_ready !== 1'b0 || pe_reset !== (k == 1) || pe_ctrl !== exp_ctrl(op, k) ||
                pe_d0 !== exp_d0(op, a) || pe_d1 !== e1 || pe_d2 !== e2) seq_ok = 1'b0;
         end
      end
      if (lat < 0) begin
         seq_ok = 1'b0;
         return;
      end
      for (int h = 0; h < hold; h++) begin
         if (res_valid !== 1'b1 || res_data !== data || cmd_ready !== 1'b0 ||
             pe_ctrl !== 11'd0 || pe_reset !== 1'b0) stall_ok = 1'b0;
         @(negedge clk);
      end
      if (res_valid !== 1'b1 || res_data !== data) stall_ok = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      idle_ok = (cmd_ready === 1'b1 && res_valid === 1'b0 && pe_ctrl === 11'd0 &&
                 pe_reset === 1'b0);
      exp_ops++;
      exp_busy += ITER + 4 + hold;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (pe_reset !== 1'b1 || cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: pe_reset=%b cmd_ready=%b required 1 0", pe_reset, cmd_ready);
      end
      n_checks++;
      if (res_valid !== 1'b0 || res_data !== '0 || pe_ctrl !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_out: res_valid=%b res_data=%h pe_ctrl=%b required zeros",
                  res_valid, res_data, pe_ctrl);
      end
      n_checks++;
      if (pe_d0 !== '0 || pe_d1 !== '0 || pe_d2 !== '0) begin
         n_fail++;
         $display("FAIL reset_d: d0=%h d1=%h d2=%h required 0", pe_d0, pe_d1, pe_d2);
      end
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1 || pe_reset !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_exit: cmd_ready=%b pe_reset=%b required 1 0", cmd_ready, pe_reset);
      end
   endtask

   task automatic test_mult();
      int lat; int acc; logic [W-1:0] d; bit sq; bit st; bit id;
      run_op(2'd0, MA, MB, 0, lat, d, sq, st, id, acc);
      n_checks++;
      if (lat != ITER + 4) begin n_fail++; $display("FAIL mult_latency: got %0d required %0d", lat, ITER + 4); end
      n_checks++;
      if (d !== MR) begin n_fail++; $display("FAIL mult_data: got %h required %h", d, MR); end
      n_checks++;
      if (!(sq && id)) begin n_fail++; $display("FAIL mult_sequence: seq=%b idle=%b required 1 1", sq, id); end
   endtask

   task automatic test_cube();
      int lat; int acc; logic [W-1:0] d; bit sq; bit st; bit id;
      run_op(2'd1, CA, rnd_trits(), 0, lat, d, sq, st, id, acc);
      n_checks++;
      if (d !== CR || lat != ITER + 4) begin
         n_fail++;
         $display("FAIL cube_data: got %h lat %0d required %h lat %0d", d, lat, CR, ITER + 4);
      end
      n_checks++;
      if (!(sq && id)) begin n_fail++; $display("FAIL cube_sequence: seq=%b idle=%b required 1 1", sq, id); end
   endtask

   task automatic test_back_to_back();
      int l1; int l2; int a1; int a2; logic [W-1:0] d1; logic [W-1:0] d2;
      bit s1; bit s2; bit t1; bit t2; bit i1; bit i2;
      run_op(2'd2, SA, SB, 0, l1, d1, s1, t1, i1, a1);
      run_op(2'd3, SA, SB, 0, l2, d2, s2, t2, i2, a2);
      n_checks++;
      if (d1 !== SADD) begin n_fail++; $display("FAIL add_data: got %h required %h", d1, SADD); end
      n_checks++;
      if (d2 !== SSUB) begin n_fail++; $display("FAIL sub_data: got %h required %h", d2, SSUB); end
      n_checks++;
      if (a2 - a1 != ITER + 5) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d cycles required %0d", a2 - a1, ITER + 5);
      end
      n_checks++;
      if (!(s1 && s2 && i1 && i2)) begin
         n_fail++;
         $display("FAIL b2b_sequence: seq=%b%b idle=%b%b required all 1", s1, s2, i1, i2);
      end
   endtask

`ifdef PE_DRIVER_PERF_EN
   task automatic test_perf();
      n_checks++;
      if (perf_ops !== 16'(exp_ops)) begin
         n_fail++;
         $display("FAIL perf_ops: got %0d required %0d", perf_ops, exp_ops);
      end
      n_checks++;
      if (perf_busy !== 32'(exp_busy)) begin
         n_fail++;
         $display("FAIL perf_busy: got %0d required %0d", perf_busy, exp_busy);
      end
   endtask
`endif

   task automatic test_backpressure();
      int lat; int acc; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] d; bit sq; bit st; bit id;
      a = rnd_trits();
      b = rnd_trits();
      run_op(2'd0, a, b, 50, lat, d, sq, st, id, acc);
      n_checks++;
      if (d !== ref_result(2'd0, a, b)) begin
         n_fail++;
         $display("FAIL bp_data: got %h required %h", d, ref_result(2'd0, a, b));
      end
      n_checks++;
      if (!st) begin n_fail++; $display("FAIL bp_stall: hold stable=%b required 1", st); end
      n_checks++;
      if (!(sq && id)) begin n_fail++; $display("FAIL bp_release: seq=%b idle=%b required 1 1", sq, id); end
   endtask

   task automatic test_reset_mid_run();
      int lat; int acc; int t; logic [W-1:0] d; bit sq; bit st; bit id;
      res_ready = 1'b1;
      cmd_op = 2'd0; cmd_a = rnd_trits(); cmd_b = rnd_trits(); cmd_valid = 1'b1;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      n_checks++;
      if (pe_ctrl !== C_MULT) begin n_fail++; $display("FAIL mid_in_run: pe_ctrl=%b required %b", pe_ctrl, C_MULT); end
      reset = 1'b0;
      #1;
      n_checks++;
      if (pe_reset !== 1'b1 || res_valid !== 1'b0 || cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: pe_reset=%b res_valid=%b cmd_ready=%b required 1 0 0",
                  pe_reset, res_valid, cmd_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || pe_ctrl !== 11'd0 || pe_reset !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_idle: cmd_ready=%b res_valid=%b pe_ctrl=%b pe_reset=%b required 1 0 0 0",
                  cmd_ready, res_valid, pe_ctrl, pe_reset);
      end
      exp_ops = 0;
      exp_busy = 0;
`ifdef PE_DRIVER_PERF_EN
      n_checks++;
      if (perf_ops !== 16'd0 || perf_busy !== 32'd0) begin
         n_fail++;
         $display("FAIL mid_perf_clear: ops=%0d busy=%0d required 0 0", perf_ops, perf_busy);
      end
`endif
      run_op(2'd0, MA, MB, 0, lat, d, sq, st, id, acc);
      n_checks++;
      if (d !== MR || lat != ITER + 4 || !sq || !id) begin
         n_fail++;
         $display("FAIL mid_after: got %h lat %0d seq %b idle %b required %h lat %0d", d, lat, sq, id,
                  MR, ITER + 4);
      end
   endtask

   task automatic test_random();
      int lat; int acc; int hold; logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b;
      logic [W-1:0] d; bit sq; bit st; bit id;
      for (int n = 0; n < 8; n++) begin
         op = 2'($urandom_range(0, 3));
         a = rnd_trits();
         b = rnd_trits();
         hold = $urandom_range(0, 3);
         run_op(op, a, b, hold, lat, d, sq, st, id, acc);
         n_checks++;
         if (d !== ref_result(op, a, b) || lat != ITER + 4) begin
            n_fail++;
            $display("FAIL rand_data[%0d] op %0d: got %h lat %0d required %h lat %0d", n, op, d, lat,
                     ref_result(op, a, b), ITER + 4);
         end
         n_checks++;
         if (!(sq && st && id)) begin
            n_fail++;
            $display("FAIL rand_seq[%0d] op %0d: seq=%b stall=%b idle=%b required 1 1 1", n, op, sq, st, id);
         end
      end
`ifdef PE_DRIVER_PERF_EN
      test_perf();
`endif
   endtask

   initial begin
      test_reset();
      test_mult();
      test_cube();
      test_back_to_back();
`ifdef PE_DRIVER_PERF_EN
      test_perf();
`endif
      test_backpressure();
      test_reset_mid_run();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
